// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves source operands through EX/MEM/WB bypasses,
// tracks outstanding loads in a pending scoreboard and holds one operand slot.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rd_wen,
  input  logic            id_is_load,
  output logic [4:0]      rf_read1,
  output logic [4:0]      rf_read2,
  input  logic [XLEN-1:0] rf_out1,
  input  logic [XLEN-1:0] rf_out2,
  input  logic            ex_fwd_wen,
  input  logic [4:0]      ex_fwd_addr,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_wen,
  input  logic [4:0]      mem_fwd_addr,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_wen,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            of_valid,
  input  logic            of_ready,
  output logic [XLEN-1:0] of_rs1_val,
  output logic [XLEN-1:0] of_rs2_val,
  output logic [4:0]      of_rd,
  output logic            of_rd_wen,
  output logic            of_is_load
);

  logic [31:0]     pending;
  logic [4:0]      src     [2];
  logic [XLEN-1:0] rf_val  [2];
  logic [XLEN-1:0] src_val [2];
  logic            src_hz  [2];
  logic            waw;
  logic            hazard;
  logic            accept;
  logic            out_hs;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign rf_read1  = id_rs1;
  assign rf_read2  = id_rs2;
  assign src[0]    = id_rs1;
  assign src[1]    = id_rs2;
  assign rf_val[0] = rf_out1;
  assign rf_val[1] = rf_out2;

  // Bypass priority is youngest first; a nonzero index is checked before any
  // address compare, so a match never fires for x0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (src[i] == 5'd0)                                 src_val[i] = '0;
      else if (ex_fwd_wen && ex_fwd_addr == src[i])       src_val[i] = ex_fwd_data;
      else if (mem_fwd_wen && mem_fwd_addr == src[i])     src_val[i] = mem_fwd_data;
      else if (wb_wen && wb_addr == src[i])               src_val[i] = wb_data;
      else                                                src_val[i] = rf_val[i];
    end
  end

  // NOTE: every signal written here gets a value on every path (default first),
  // otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_hz[i] = (src[i] != 5'd0) && !(wb_wen && wb_addr == src[i]) &&
                  (pending[src[i]] || (of_valid && of_rd_wen && of_rd == src[i]));
      hazard    = hazard | src_hz[i];
    end
    waw    = id_is_load && id_rd_wen && (id_rd != 5'd0) && pending[id_rd] &&
             !(wb_wen && wb_addr == id_rd);
    hazard = hazard | waw;
  end

  assign id_ready = (~of_valid | of_ready) & ~hazard & ~flush;
  assign accept   = id_valid & id_ready;
  assign out_hs   = of_valid & of_ready;

  // A flushed slot is discarded, so it must not mark its destination pending.
  assign set_mask = (out_hs && of_is_load && of_rd_wen && of_rd != 5'd0 && !flush)
                    ? (32'd1 << of_rd) : 32'd0;
  assign clr_mask = wb_wen ? (32'd1 << wb_addr) : 32'd0;

  // NOTE: the scoreboard is only 32 flops and a stale pending bit after reset
  // would stall forever, so it is reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_valid   <= 1'b0;
      of_rs1_val <= '0;
      of_rs2_val <= '0;
      of_rd      <= '0;
      of_rd_wen  <= 1'b0;
      of_is_load <= 1'b0;
    end else if (accept) begin
      of_valid   <= 1'b1;
      of_rs1_val <= src_val[0];
      of_rs2_val <= src_val[1];
      of_rd      <= id_rd;
      of_rd_wen  <= id_rd_wen;
      of_is_load <= id_is_load;
    end else if (flush || of_ready) begin
      of_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of register values.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports id_valid input 1 and id_ready output 1; decode-to-fetch handshake.
REQ-005 SHALL have ports id_rs1 and id_rs2 input 5, and id_rd input 5; source and destination register indices.
REQ-006 SHALL have ports id_rd_wen input 1 and id_is_load input 1; destination write enable and load flag.
REQ-007 SHALL have ports rf_read1 and rf_read2 output 5; register file read addresses, driven combinationally from id_rs1 and id_rs2.
REQ-008 SHALL have ports rf_out1 and rf_out2 input XLEN; combinational register file read data.
REQ-009 SHALL have ports ex_fwd_wen input 1, ex_fwd_addr input 5, ex_fwd_data input XLEN; non-load result in EX.
REQ-010 SHALL have ports mem_fwd_wen input 1, mem_fwd_addr input 5, mem_fwd_data input XLEN; non-load result in MEM.
REQ-011 SHALL have ports wb_wen input 1, wb_addr input 5, wb_data input XLEN; value being written to the register file this cycle.
REQ-012 SHALL have port flush input 1; discards the held operand slot.
REQ-013 SHALL have ports of_valid output 1 and of_ready input 1; fetch-to-execute handshake.
REQ-014 SHALL have ports of_rs1_val and of_rs2_val output XLEN, of_rd output 5, of_rd_wen output 1, of_is_load output 1; registered operand slot.

Function
REQ-015 SHALL resolve each source value by priority: index 0 gives 0; EX match; MEM match; WB match; register file data. A match requires the corresponding wen set and an equal nonzero address.
REQ-016 SHALL keep a 32-bit pending scoreboard, one bit per register; bit 0 is always 0.
REQ-017 SHALL set pending[of_rd] on an output handshake when of_is_load=1, of_rd_wen=1 and of_rd!=0.
REQ-018 SHALL clear pending[wb_addr] when wb_wen=1. If a set and a clear hit the same register in the same cycle, the set SHALL win.
REQ-019 SHALL assert hazard when any nonzero source index matches either of the following, unless wb_wen=1 with wb_addr equal to that source:
- a set pending bit;
- the held slot, with of_valid=1 and of_rd_wen=1.
REQ-020 SHALL also assert hazard when id_is_load=1, id_rd_wen=1, id_rd!=0 and pending[id_rd] is set and not cleared this cycle (WAW).
REQ-021 SHALL drive id_ready = (~of_valid | of_ready) & ~hazard & ~flush, combinationally.
REQ-022 SHALL load the slot when id_valid and id_ready are both set. On load, of_valid<=1 and the resolved values and control fields are captured. Latency SHALL be 1 cycle from accept to of_valid.
REQ-023 SHALL clear of_valid when of_ready=1 and no new accept occurs. Otherwise of_valid and the slot contents SHALL hold, stable while of_valid=1 and of_ready=0.
REQ-024 SHALL, on flush=1, clear of_valid at the next edge, block any accept, and leave the scoreboard unchanged.
REQ-025 SHALL hold slot contents unchanged when of_valid=0 and no accept occurs.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force:
- of_valid=0;
- of_rs1_val=0 and of_rs2_val=0;
- of_rd=0, of_rd_wen=0, of_is_load=0;
- all pending bits to 0.
REQ-027 SHALL keep id_ready equal to id_valid-independent ~flush during reset, since hazard=0 and of_valid=0.
REQ-028 SHALL discard an in-flight slot when reset is asserted mid-operation; the first accept after release SHALL behave as from the reset state.

Verification
REQ-029 SHALL cover the bypass case: rs1=5 with RF x5=0x11, WB x5=0x22, MEM x5=0x33, EX x5=0x44 all active -> of_rs1_val=0x44; with EX inactive -> 0x33; with rs1=0 -> 0.
REQ-030 SHALL cover load-use: load x7 handshaken out, next instruction reads x7 -> id_ready=0 until wb_wen with wb_addr=7 and wb_data=0xDEAD; accepted that cycle -> of_rs1_val=0xDEAD, pending[7]=0.
REQ-031 SHALL cover slot dependency: slot holds add x3 with of_ready=0, ID reads x3 -> id_ready=0; after the slot leaves, ex_fwd x3=0x9 -> accepted with value 0x9.
REQ-032 SHALL cover backpressure: of_ready=0 for 3 cycles with slot valid -> outputs stable and id_ready=0; of_ready=1 -> next accept on the same cycle.
REQ-033 SHALL cover the same-cycle set/clear race: load x4 handshaken while wb clears x4 -> pending[4]=1. A second load to x4 then SHALL stall until WB of x4.
REQ-034 SHALL cover flush and reset: flush with the slot valid -> of_valid=0 next cycle with pending unchanged; rst_n low mid-stall -> all outputs 0 and pending cleared immediately.
